// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO and models multi-cycle
// mult/div latency with an IDLE/BUSY machine that feeds the stall unit.
module mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  MDOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Req,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDOut
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned PROD_W = 64;
   localparam int unsigned CNT_W  = 4;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic [DATA_W-1:0]   phi_q, phi_d;
   logic [DATA_W-1:0]   plo_q, plo_d;
   logic                dz_q, dz_d;

   logic [PROD_W-1:0]   a_sx, b_sx, prod_s, prod_u;
   logic [DATA_W-1:0]   div_b;
   logic [DATA_W-1:0]   quot_s, rem_s, quot_u, rem_u;
   logic                b_zero;

   // Arithmetic datapath; a zero divisor is swapped for 1 so the divider
   // never sees an undefined case (the result is discarded anyway).
   always_comb begin
      a_sx   = {{DATA_W{A[DATA_W-1]}}, A};
      b_sx   = {{DATA_W{B[DATA_W-1]}}, B};
      prod_s = a_sx * b_sx;
      prod_u = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
      b_zero = (B == '0);
      div_b  = b_zero ? DATA_W'(1) : B;
      quot_s = DATA_W'($signed(A) / $signed(div_b));
      rem_s  = DATA_W'($signed(A) % $signed(div_b));
      quot_u = A / div_b;
      rem_u  = A % div_b;
   end

   // Next-state logic: accept ops in IDLE, count down and commit in BUSY.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE: begin
            if (!Req) begin
               if (Start && (MDOp == OP_MULT || MDOp == OP_MULTU ||
                             MDOp == OP_DIV  || MDOp == OP_DIVU)) begin
                  state_d = S_BUSY;
                  dz_d    = 1'b0;
                  case (MDOp)
                     OP_MULT: begin
                        phi_d = prod_s[PROD_W-1:DATA_W];
                        plo_d = prod_s[DATA_W-1:0];
                        cnt_d = CNT_W'(MULT_CYCLES);
                     end
                     OP_MULTU: begin
                        phi_d = prod_u[PROD_W-1:DATA_W];
                        plo_d = prod_u[DATA_W-1:0];
                        cnt_d = CNT_W'(MULT_CYCLES);
                     end
                     OP_DIV: begin
                        phi_d = rem_s;
                        plo_d = quot_s;
                        dz_d  = b_zero;
                        cnt_d = CNT_W'(DIV_CYCLES);
                     end
                     default: begin
                        phi_d = rem_u;
                        plo_d = quot_u;
                        dz_d  = b_zero;
                        cnt_d = CNT_W'(DIV_CYCLES);
                     end
                  endcase
               end else if (MDOp == OP_MTHI) begin
                  hi_d = A;
               end else if (MDOp == OP_MTLO) begin
                  lo_d = A;
               end
            end
         end
         S_BUSY: begin
            // In-flight op is never cancelled; Start/mt/Req are ignored here.
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (!dz_q) begin
                  hi_d = phi_q;
                  lo_d = plo_q;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and register file flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
         dz_q    <= dz_d;
      end
   end

   // Read port for mfhi/mflo; sees committed HI/LO only.
   always_comb begin
      MDOut = '0;
      case (MDOp)
         OP_MFHI: MDOut = hi_q;
         OP_MFLO: MDOut = lo_q;
         default: MDOut = '0;
      endcase
   end

   assign Busy = (state_q == S_BUSY);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus drives a spec-level model and queues
// expected completions/reads; a monitor checks them as the DUT presents them.
module tb_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [3:0]  MDOp;
   logic [31:0] A, B;
   logic        Req;
   logic        Busy;
   logic [31:0] HI, LO, MDOut;

   always #5 clk = ~clk;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .Start (Start),
      .MDOp  (MDOp),
      .A     (A),
      .B     (B),
      .Req   (Req),
      .Busy  (Busy),
      .HI    (HI),
      .LO    (LO),
      .MDOut (MDOut)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } cmp_t;

   cmp_t        cq[$];
   logic [31:0] rdq[$];
   int          errors = 0;
   int          checks = 0;

   // model state
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   logic        m_dz;
   int          m_rem;

   // monitor state
   logic        busy_prev;
   int          bc;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // Architectural result of an md op, from plain 64-bit arithmetic.
   task automatic ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l, output logic dz);
      longint          sa, sb, ps, q, r;
      longint unsigned pu, ua, ub, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      dz = 1'b0;
      h  = m_hi;
      l  = m_lo;
      case (op)
         4'd1: begin
            ps = sa * sb;
            h  = ps[63:32];
            l  = ps[31:0];
         end
         4'd2: begin
            pu = ua * ub;
            h  = pu[63:32];
            l  = pu[31:0];
         end
         4'd3: begin
            if (b == 32'd0) dz = 1'b1;
            else begin
               q = sa / sb;
               r = sa - q * sb;
               h = r[31:0];
               l = q[31:0];
            end
         end
         default: begin
            if (b == 32'd0) dz = 1'b1;
            else begin
               uq = ua / ub;
               ur = ua - uq * ub;
               h  = ur[31:0];
               l  = uq[31:0];
            end
         end
      endcase
   endtask

   task automatic model_reset();
      m_hi  = '0;
      m_lo  = '0;
      m_phi = '0;
      m_plo = '0;
      m_dz  = 1'b0;
      m_rem = 0;
   endtask

   // One clock of stimulus: drive inputs, queue expectations, advance model.
   task automatic step(input logic st, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rq);
      logic [31:0] h, l;
      logic        dz;
      Start = st;
      MDOp  = op;
      A     = a;
      B     = b;
      Req   = rq;
      if (op == 4'd7) rdq.push_back(m_hi);
      else if (op == 4'd8) rdq.push_back(m_lo);
      if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0 && !m_dz) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (!rq) begin
         if (st && op >= 4'd1 && op <= 4'd4) begin
            ref_md(op, a, b, h, l, dz);
            m_phi = h;
            m_plo = l;
            m_dz  = dz;
            m_rem = (op <= 4'd2) ? 5 : 10;
            cq.push_back('{dz ? m_hi : h, dz ? m_lo : l, m_rem});
         end else if (op == 4'd5) begin
            m_hi = a;
         end else if (op == 4'd6) begin
            m_lo = a;
         end
      end
      @(posedge clk);
      #1;
      Start = 1'b0;
      MDOp  = 4'd0;
      Req   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
   endtask

   // Monitor: checks reads every cycle and each completion on Busy falling.
   initial begin
      busy_prev = 1'b0;
      bc        = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            busy_prev = 1'b0;
            bc        = 0;
         end else begin
            if (MDOp == 4'd7 || MDOp == 4'd8) begin
               if (rdq.size() == 0) fail("mdout_unexpected_read");
               else chk32("mdout", MDOut, rdq.pop_front());
            end else begin
               chk32("mdout_idle_zero", MDOut, 32'd0);
            end
            if (Busy) begin
               bc++;
            end else if (busy_prev) begin
               if (cq.size() == 0) begin
                  fail("unexpected_completion");
               end else begin
                  cmp_t e;
                  e = cq.pop_front();
                  chk32("done_hi", HI, e.hi);
                  chk32("done_lo", LO, e.lo);
                  chk32("busy_len", 32'(bc), 32'(e.n));
               end
               bc = 0;
            end
            busy_prev = Busy;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      Start = 1'b0;
      MDOp  = 4'd0;
      A     = '0;
      B     = '0;
      Req   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk32("rst_busy", 32'(Busy), 32'd0);
      chk32("rst_hi", HI, 32'd0);
      chk32("rst_lo", LO, 32'd0);
      MDOp = 4'd7;
      #1;
      chk32("rst_mfhi", MDOut, 32'd0);
      MDOp  = 4'd0;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // mult / multu of -2 * 3
      step(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
      idle(5);
      chk32("mult_hi", HI, 32'hFFFF_FFFF);
      chk32("mult_lo", LO, 32'hFFFF_FFFA);
      step(1'b1, 4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
      idle(5);
      chk32("multu_hi", HI, 32'h0000_0002);
      chk32("multu_lo", LO, 32'hFFFF_FFFA);

      // div -7 / 2
      step(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      idle(10);
      chk32("div_hi", HI, 32'hFFFF_FFFF);
      chk32("div_lo", LO, 32'hFFFF_FFFD);

      // divu by zero keeps HI/LO
      step(1'b0, 4'd5, 32'h11, 32'd0, 1'b0);
      step(1'b0, 4'd6, 32'h22, 32'd0, 1'b0);
      step(1'b1, 4'd4, 32'd7, 32'd0, 1'b0);
      idle(10);
      chk32("divz_hi", HI, 32'h11);
      chk32("divz_lo", LO, 32'h22);

      // mthi then reads
      step(1'b0, 4'd5, 32'h1234_5678, 32'd0, 1'b0);
      chk32("mthi_hi", HI, 32'h1234_5678);
      step(1'b0, 4'd8, 32'd0, 32'd0, 1'b0);
      step(1'b0, 4'd7, 32'd0, 32'd0, 1'b0);

      // mthi during BUSY is ignored
      step(1'b1, 4'd1, 32'd2, 32'd3, 1'b0);
      step(1'b0, 4'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
      idle(4);
      chk32("mthi_busy_hi", HI, 32'd0);
      chk32("mthi_busy_lo", LO, 32'd6);

      // Start squashed by Req
      step(1'b1, 4'd1, 32'd5, 32'd5, 1'b1);
      chk32("req_start_busy", 32'(Busy), 32'd0);
      chk32("req_start_lo", LO, 32'd6);

      // Req mid-mult does not cancel it
      step(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      idle(2);
      step(1'b0, 4'd6, 32'h5555_5555, 32'd0, 1'b1);
      idle(2);
      chk32("req_mid_hi", HI, 32'hFFFF_FFFE);
      chk32("req_mid_lo", LO, 32'h0000_0001);

      // Start while BUSY is ignored
      step(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
      step(1'b1, 4'd1, 32'd9, 32'd9, 1'b0);
      idle(9);
      chk32("busy_start_hi", HI, 32'd2);
      chk32("busy_start_lo", LO, 32'd14);

      // Start on the completion edge is ignored; next cycle accepted
      step(1'b1, 4'd1, 32'd3, 32'd4, 1'b0);
      idle(4);
      step(1'b1, 4'd2, 32'd6, 32'd7, 1'b0);
      step(1'b1, 4'd2, 32'd6, 32'd7, 1'b0);
      idle(5);
      chk32("b2b_lo", LO, 32'd42);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic        st, rq;
         logic [3:0]  op;
         logic [31:0] a, b;
         st = ($urandom_range(0, 2) != 0);
         op = 4'($urandom_range(0, 9));
         a  = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = 32'($urandom_range(1, 9));
            3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: b = $urandom;
         endcase
         rq = ($urandom_range(0, 9) == 0);
         step(st, op, a, b, rq);
      end
      idle(12);

      // reset in the middle of a divide
      step(1'b1, 4'd3, 32'd1000, 32'd3, 1'b0);
      idle(3);
      #2;
      reset = 1'b0;
      #1;
      chk32("midrst_busy", 32'(Busy), 32'd0);
      chk32("midrst_hi", HI, 32'd0);
      chk32("midrst_lo", LO, 32'd0);
      cq.delete();
      rdq.delete();
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      step(1'b0, 4'd8, 32'd0, 32'd0, 1'b0);
      step(1'b0, 4'd7, 32'd0, 32'd0, 1'b0);
      idle(12);
      chk32("midrst_idle_busy", 32'(Busy), 32'd0);

      chk32("pending_completions", 32'(cq.size()), 32'd0);
      chk32("pending_reads", 32'(rdq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the E stage of the pipelined MIPS core. Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E, owns the HI/LO registers, and models multi-cycle latency with an IDLE/BUSY state machine. Its `Busy` output, together with the E-stage `Start` pulse, feeds the hazard/stall unit, which freezes D while a mt/mf/md instruction waits on the unit.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu (1..15)
- `DIV_CYCLES`, 10, busy cycles for div/divu (1..15)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `Start`  in  1  E-stage md instruction (mult/multu/div/divu) valid this cycle
- `MDOp`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others none
- `A`  in  32  rs operand (forwarded)
- `B`  in  32  rt operand (forwarded)
- `Req`  in  1  exception/interrupt taken this cycle; E-stage instruction is squashed
- `Busy`  out  1  operation in flight
- `HI`  out  32  architectural HI
- `LO`  out  32  architectural LO
- `MDOut`  out  32  mfhi/mflo read data

## Operation
- States: IDLE, BUSY. 4-bit down-counter `cnt`; pending result regs `pHI`, `pLO`.
- IDLE, `Start`=1, `Req`=0, MDOp in {1..4}: latch result into `pHI/pLO`, load `cnt` with MULT_CYCLES or DIV_CYCLES, go BUSY.
  - mult: signed 64-bit A*B, pHI=[63:32], pLO=[31:0]; multu unsigned.
  - div: signed, pLO=A/B truncated toward zero, pHI=A%B (sign of A); divu unsigned.
  - B==0 (div/divu): still goes BUSY for DIV_CYCLES; at completion HI/LO keep previous values.
- BUSY: `cnt` decrements each edge; edge where `cnt`==1: HI<=pHI, LO<=pLO (unless div-by-zero), return IDLE.
- mthi/mtlo (MDOp 5/6, `Req`=0): HI<=A / LO<=A at next edge; only honored in IDLE (stall unit guarantees this); ignored in BUSY.
- `Start` or mthi/mtlo with `Req`=1: ignored entirely, no state change.
- `Start` while BUSY: ignored (illegal under correct stalling; must not corrupt pending op).
- `Req` while BUSY: in-flight op is NOT cancelled (it belongs to an older, committed instruction); completes normally.
- `MDOut`: combinational; MDOp 7 -> HI, 8 -> LO, else 0. Reads current HI/LO registers (no bypass of pending result).
- `Busy` = (state==BUSY), registered.

## Timing
- Reset (async, `reset`=0): state IDLE, cnt=0, HI=LO=pHI=pLO=0, Busy=0, MDOut reflects 0 for mf ops.
- Reset deassertion mid-operation: unit is in IDLE, pending op lost.
- Start sampled at edge t: Busy=1 from t through t+N (N = MULT_CYCLES/DIV_CYCLES), HI/LO update and Busy=0 at edge t+N; N cycles of Busy.
- Back-to-back: a new Start is accepted at the same edge Busy falls only if state is IDLE before that edge; it is therefore accepted earliest at edge t+N+1 (stall unit holds D while Start||Busy).
- mthi/mtlo: single-cycle, visible on HI/LO and MDOut the cycle after the edge.
- mfhi/mflo following completion: first cycle with Busy=0 sees the new HI/LO.
- Counter never wraps: loaded only in IDLE, stops at transition to IDLE.

## Test plan
- Reset: `reset`=0 mid-BUSY -> Busy=0, HI=LO=0 immediately; after release, mflo MDOut=0.
- mult A=0xFFFFFFFE (-2), B=3 at edge t -> Busy high 5 cycles, at edge t+5 HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 with HI=0x11, LO=0x22 -> Busy 10 cycles, HI/LO stay 0x11/0x22.
- mthi A=0x12345678 then mflo/mfhi -> HI=0x12345678 next cycle, MDOut(mfhi)=0x12345678; mthi asserted during BUSY -> HI unchanged.
- Start with `Req`=1 -> Busy stays 0, HI/LO unchanged; `Req`=1 at cycle 3 of a mult -> mult still completes with correct HI/LO.
- Start pulsed again while BUSY with different operands -> ignored; original result committed at original edge.
